// File: rtl/reduction_flag_counter.sv
`default_nettype none
// ============================================================================
// Module   : reduction_flag_counter
// Brief    : Counts high flags per window of accepted samples and reports the
//            counts on a held valid/ready output. Optional macro
//            REDFLAG_ALL_HI_EN adds the all_hi count.
// Revision : 1.0 - initial release
// ============================================================================
module reduction_flag_counter #(
   parameter int WINDOW = 8,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   input  logic             u,
   input  logic             v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_x,
   output logic [CNT_W-1:0] cnt_y,
   output logic [CNT_W-1:0] cnt_z,
   output logic [CNT_W-1:0] cnt_u,
   output logic [CNT_W-1:0] cnt_v
`ifdef REDFLAG_ALL_HI_EN
   ,
   output logic [CNT_W-1:0] all_hi
`endif
);

`ifdef REDFLAG_ALL_HI_EN
   localparam int C_NF = 6;
`else
   localparam int C_NF = 5;
`endif
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);

   typedef enum logic [0:0] {
      ST_ACCUM  = 1'b0,
      ST_REPORT = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_samp;
   logic [CNT_W-1:0] r_acc [C_NF];
   logic [CNT_W-1:0] r_cnt [C_NF];
   logic [C_NF-1:0]  w_flags;
   logic             w_accept;

`ifdef REDFLAG_ALL_HI_EN
   assign w_flags = {x & y & z & u & v, x, y, z, u, v};
`else
   assign w_flags = {x, y, z, u, v};
`endif

   assign w_accept = in_valid & r_in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_samp      <= '0;
         for (int i = 0; i < C_NF; i++) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else if (flush) begin
         // Result registers deliberately keep their last window.
         r_state     <= ST_ACCUM;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_samp      <= '0;
         for (int i = 0; i < C_NF; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  if (r_samp == C_LAST) begin
                     for (int i = 0; i < C_NF; i++) begin
                        r_cnt[i] <= r_acc[i] + CNT_W'(w_flags[i]);
                        r_acc[i] <= '0;
                     end
                     r_samp      <= '0;
                     r_state     <= ST_REPORT;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     for (int i = 0; i < C_NF; i++) begin
                        r_acc[i] <= r_acc[i] + CNT_W'(w_flags[i]);
                     end
                     r_samp <= r_samp + 1'b1;
                  end
               end
            end
            ST_REPORT: begin
               if (out_ready) begin
                  r_state     <= ST_ACCUM;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_ACCUM;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign cnt_x     = r_cnt[4];
   assign cnt_y     = r_cnt[3];
   assign cnt_z     = r_cnt[2];
   assign cnt_u     = r_cnt[1];
   assign cnt_v     = r_cnt[0];
`ifdef REDFLAG_ALL_HI_EN
   assign all_hi    = r_cnt[5];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reduction_flag_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduction_flag_counter
// Brief    : Directed self-checking bench for reduction_flag_counter, WINDOW=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduction_flag_counter;

   localparam int WINDOW = 4;
   localparam int CNT_W  = 4;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic             x, y, z, u, v;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] cnt_x, cnt_y, cnt_z, cnt_u, cnt_v;
`ifdef REDFLAG_ALL_HI_EN
   logic [CNT_W-1:0] all_hi;
`endif

   int n_vec;
   int n_err;

   reduction_flag_counter #(
      .WINDOW(WINDOW),
      .CNT_W (CNT_W)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .y        (y),
      .z        (z),
      .u        (u),
      .v        (v),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .cnt_x    (cnt_x),
      .cnt_y    (cnt_y),
      .cnt_z    (cnt_z),
      .cnt_u    (cnt_u),
      .cnt_v    (cnt_v)
`ifdef REDFLAG_ALL_HI_EN
      ,
      .all_hi   (all_hi)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [4:0] f);
      in_valid = vld;
      {x, y, z, u, v} = f;
   endtask

   task automatic send(input logic [4:0] f);
      drive(1'b1, f);
      step();
      drive(1'b0, 5'b00000);
   endtask

   task automatic chk_cnts(input string tag, input int ex, input int ey, input int ez,
                           input int eu, input int ev, input int eall);
      chk({tag, ".x"}, 32'(cnt_x), ex);
      chk({tag, ".y"}, 32'(cnt_y), ey);
      chk({tag, ".z"}, 32'(cnt_z), ez);
      chk({tag, ".u"}, 32'(cnt_u), eu);
      chk({tag, ".v"}, 32'(cnt_v), ev);
`ifdef REDFLAG_ALL_HI_EN
      chk({tag, ".all"}, 32'(all_hi), eall);
`else
      if (eall < 0) $display("unused all_hi expectation");
`endif
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 5'b11111);

      // Reset held with active input traffic
      step();
      step();
      chk_cnts("rst", 0, 0, 0, 0, 0, 0);
      chk("rst.ov", 32'(out_valid), 0);
      rst_n = 1'b1;
      drive(1'b0, 5'b00000);
      chk("rst.ir0", 32'(in_ready), 1);
      step();
      chk("rst.ir1", 32'(in_ready), 1);
      chk("rst.ov1", 32'(out_valid), 0);

      // Basic window, back-to-back accepts
      drive(1'b1, 5'b10101); step();
      drive(1'b1, 5'b11111); step();
      drive(1'b1, 5'b00000); step();
      chk("basic.ov_pre", 32'(out_valid), 0);
      drive(1'b1, 5'b10001); step();
      drive(1'b0, 5'b00000);
      chk("basic.ov", 32'(out_valid), 1);
      chk("basic.ir", 32'(in_ready), 0);
      chk_cnts("basic", 3, 1, 2, 1, 3, 1);
      step();
      step();
      chk("basic.ov_hold", 32'(out_valid), 1);
      chk("basic.ir_hold", 32'(in_ready), 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("basic.ov_done", 32'(out_valid), 0);
      chk("basic.ir_done", 32'(in_ready), 1);

      // Bubbles between samples, then long backpressure with ignored traffic
      send(5'b11000);
      drive(1'b0, 5'b11111); step();
      send(5'b01100);
      drive(1'b0, 5'b11111); step();
      drive(1'b0, 5'b11111); step();
      send(5'b00110);
      send(5'b00011);
      chk("bp.ov", 32'(out_valid), 1);
      chk_cnts("bp", 1, 2, 2, 2, 1, 0);
      drive(1'b1, 5'b11111);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp.ov_stall", 32'(out_valid), 1);
         chk("bp.x_stall", 32'(cnt_x), 1);
      end
      chk_cnts("bp.stall", 1, 2, 2, 2, 1, 0);
      drive(1'b0, 5'b00000);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < WINDOW; i++) send(5'b00001);
      chk("bp2.ov", 32'(out_valid), 1);
      chk_cnts("bp2", 0, 0, 0, 0, 4, 0);
      out_ready = 1'b1;
      step();

      // Back-to-back windows with out_ready tied high
      drive(1'b1, 5'b11111);
      for (int i = 0; i < WINDOW; i++) step();
      chk("b2b.ov1", 32'(out_valid), 1);
      chk_cnts("b2b.w1", 4, 4, 4, 4, 4, 4);
      drive(1'b1, 5'b00000);
      step();
      chk("b2b.ov_drop", 32'(out_valid), 0);
      chk("b2b.ir", 32'(in_ready), 1);
      for (int i = 0; i < WINDOW; i++) step();
      chk("b2b.ov2", 32'(out_valid), 1);
      chk_cnts("b2b.w2", 0, 0, 0, 0, 0, 0);
      drive(1'b0, 5'b00000);
      step();
      chk("b2b.ov_end", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Flush mid-window discards partial sums and the concurrent sample
      send(5'b11111);
      send(5'b11111);
      flush = 1'b1;
      drive(1'b1, 5'b11111);
      step();
      flush = 1'b0;
      drive(1'b0, 5'b00000);
      chk("fl.ov", 32'(out_valid), 0);
      for (int i = 0; i < WINDOW; i++) send(5'b10000);
      chk("fl.ov_res", 32'(out_valid), 1);
      chk_cnts("fl", 4, 0, 0, 0, 0, 0);

      // Flush during REPORT drops the result but holds the counts
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flr.ov", 32'(out_valid), 0);
      chk("flr.ir", 32'(in_ready), 1);
      chk_cnts("flr", 4, 0, 0, 0, 0, 0);

      // Reset mid-window, then a clean window counts from zero
      send(5'b11111);
      send(5'b11111);
      send(5'b11111);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rm.ov", 32'(out_valid), 0);
      chk_cnts("rm", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < WINDOW; i++) send(5'b01000);
      chk("rm2.ov", 32'(out_valid), 1);
      chk_cnts("rm2", 0, 4, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
